// File: rtl/tqvp_stevej_wdt_reset_ctl_if.sv
// Peripheral register bus between the TinyQV core and the watchdog reset controller.
// The controller sits on the slave side; the core or bench drives the master side.
interface tqvp_stevej_wdt_reset_ctl_if;
    logic [5:0]  address;
    logic [31:0] data_in;
    logic [1:0]  data_write_n;
    logic [1:0]  data_read_n;
    logic [31:0] data_out;
    logic        data_ready;

    modport slave (
        input  address,
        input  data_in,
        input  data_write_n,
        input  data_read_n,
        output data_out,
        output data_ready
    );

    modport master (
        output address,
        output data_in,
        output data_write_n,
        output data_read_n,
        input  data_out,
        input  data_ready
    );
endinterface

// File: rtl/tqvp_stevej_wdt_reset_ctl.sv
// Watchdog escalation stage: turns a sustained bark into a grace countdown and then a
// fixed-width active-low reset pulse, with sticky status and a saturating bite counter.
//
//  state   | meaning
//  --------+--------------------------------------------------------------
//  IDLE    | waiting for an enabled expiry or a forced bite
//  WARN    | grace countdown running; pat, expiry drop or disable cancels
//  BITE    | o_wdt_rst_n held low for PULSE_LEN cycles
//  HOLDOFF | pulse done; wait for expiry to drop before re-arming
module tqvp_stevej_wdt_reset_ctl #(
    parameter int PULSE_LEN = 16,
    parameter int CNT_W     = 8,
    parameter int GRACE_RST = 1000
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          i_wdt_expired,
    input  logic                          i_wdt_pat,
    tqvp_stevej_wdt_reset_ctl_if.slave    bus,
    output logic                          o_wdt_rst_n,
    output logic                          o_irq
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WARN    = 2'd1,
        ST_BITE    = 2'd2,
        ST_HOLDOFF = 2'd3
    } state_t;

    localparam logic [5:0]  A_CTRL     = 6'h10;
    localparam logic [5:0]  A_GRACE    = 6'h11;
    localparam logic [5:0]  A_STATUS   = 6'h12;
    localparam logic [5:0]  A_CLEAR    = 6'h13;
    localparam logic [31:0] PULSE_LAST = 32'(PULSE_LEN - 1);
    localparam logic [31:0] GRACE_INIT = 32'(GRACE_RST);

    state_t             r_state;
    logic [31:0]        r_cnt;
    logic [31:0]        r_grace;
    logic               r_enable;
    logic               r_bark_sticky;
    logic               r_bite_sticky;
    logic [CNT_W-1:0]   r_bite_cnt;

    logic               w_wr;
    logic               w_wr_ctrl;
    logic               w_wr_grace;
    logic               w_wr_clear;
    logic               w_force;
    logic               w_bark_clr;
    logic               w_cancel;
    logic [CNT_W-1:0]   w_bite_cnt_inc;
    logic [31:0]        w_grace_next;
    logic [31:0]        w_status;
    logic [31:0]        w_rdata;
    logic               w_unused;

    assign w_wr       = (bus.data_write_n != 2'b11);
    assign w_wr_ctrl  = w_wr && (bus.address == A_CTRL);
    assign w_wr_grace = w_wr && (bus.address == A_GRACE);
    assign w_wr_clear = w_wr && (bus.address == A_CLEAR);
    assign w_force    = w_wr_ctrl && bus.data_in[2];
    assign w_bark_clr = (w_wr_ctrl && bus.data_in[1]) || w_wr_clear;
    assign w_cancel   = i_wdt_pat || !i_wdt_expired || !r_enable;

    assign w_bite_cnt_inc = (r_bite_cnt == {CNT_W{1'b1}}) ? r_bite_cnt
                                                           : r_bite_cnt + 1'b1;

    // Sub-word writes only replace the written lanes of GRACE.
    always_comb begin
        w_grace_next = r_grace;
        case (bus.data_write_n)
            2'b00:   w_grace_next[7:0]  = bus.data_in[7:0];
            2'b01:   w_grace_next[15:0] = bus.data_in[15:0];
            2'b10:   w_grace_next       = bus.data_in;
            default: w_grace_next       = r_grace;
        endcase
    end

    // Status/clear updates come first so that FSM-driven sticky sets below override them.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_cnt         <= '0;
            r_grace       <= GRACE_INIT;
            r_enable      <= 1'b0;
            r_bark_sticky <= 1'b0;
            r_bite_sticky <= 1'b0;
            r_bite_cnt    <= '0;
            o_wdt_rst_n   <= 1'b1;
        end else begin
            if (w_wr_ctrl)  r_enable <= bus.data_in[0];
            if (w_wr_grace) r_grace  <= w_grace_next;
            if (w_bark_clr) r_bark_sticky <= 1'b0;
            if (w_wr_clear) begin
                r_bite_sticky <= 1'b0;
                r_bite_cnt    <= '0;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_force) begin
                        r_state       <= ST_BITE;
                        r_cnt         <= PULSE_LAST;
                        r_bite_sticky <= 1'b1;
                        r_bite_cnt    <= w_bite_cnt_inc;
                        o_wdt_rst_n   <= 1'b0;
                    end else if (r_enable && i_wdt_expired) begin
                        r_state       <= ST_WARN;
                        r_cnt         <= r_grace;
                        r_bark_sticky <= 1'b1;
                    end
                end
                ST_WARN: begin
                    if (w_force || (!w_cancel && r_cnt == '0)) begin
                        r_state       <= ST_BITE;
                        r_cnt         <= PULSE_LAST;
                        r_bite_sticky <= 1'b1;
                        r_bite_cnt    <= w_bite_cnt_inc;
                        o_wdt_rst_n   <= 1'b0;
                    end else if (w_cancel) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 32'd1;
                    end
                end
                ST_BITE: begin
                    if (r_cnt == '0) begin
                        r_state     <= ST_HOLDOFF;
                        o_wdt_rst_n <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 32'd1;
                    end
                end
                ST_HOLDOFF: begin
                    if (!i_wdt_expired) r_state <= ST_IDLE;
                end
                default: begin
                    r_state     <= ST_IDLE;
                    o_wdt_rst_n <= 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        w_status               = '0;
        w_status[8 +: CNT_W]   = r_bite_cnt;
        w_status[3]            = r_bite_sticky;
        w_status[2]            = r_bark_sticky;
        w_status[1:0]          = r_state;
    end

    always_comb begin
        w_rdata = '0;
        case (bus.address)
            A_CTRL:   w_rdata = {31'b0, r_enable};
            A_GRACE:  w_rdata = r_grace;
            A_STATUS: w_rdata = w_status;
            default:  w_rdata = '0;
        endcase
    end

    assign bus.data_out   = w_rdata;
    assign bus.data_ready = 1'b1;
    assign o_irq          = r_bark_sticky;

    // Reads have no side effects, so the read strobe is not needed.
    assign w_unused = ^bus.data_read_n;

endmodule

// File: tb/tb_tqvp_stevej_wdt_reset_ctl.sv
// Directed bench for the watchdog reset controller: latency, pulse width, cancel races,
// forced bites, counter saturation, mid-pulse reset and GRACE lane writes.
module tb_tqvp_stevej_wdt_reset_ctl;

    localparam logic [5:0] A_CTRL   = 6'h10;
    localparam logic [5:0] A_GRACE  = 6'h11;
    localparam logic [5:0] A_STATUS = 6'h12;
    localparam logic [5:0] A_CLEAR  = 6'h13;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic wdt_expired = 1'b0;
    logic wdt_pat = 1'b0;
    logic wdt_rst_n;
    logic irq;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    tqvp_stevej_wdt_reset_ctl_if bus ();

    tqvp_stevej_wdt_reset_ctl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_wdt_expired (wdt_expired),
        .i_wdt_pat     (wdt_pat),
        .bus           (bus),
        .o_wdt_rst_n   (wdt_rst_n),
        .o_irq         (irq)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [5:0] a, input logic [31:0] d, input logic [1:0] wn);
        bus.address      = a;
        bus.data_in      = d;
        bus.data_write_n = wn;
        tick();
        bus.data_write_n = 2'b11;
    endtask

    task automatic rd(input logic [5:0] a, output logic [31:0] d);
        bus.address = a;
        #1;
        d = bus.data_out;
    endtask

    task automatic wait_high(output int cycles);
        cycles = 0;
        while (wdt_rst_n !== 1'b1 && cycles < 100) begin
            tick();
            cycles++;
        end
    endtask

    task automatic wait_low(output int cycles);
        cycles = 0;
        while (wdt_rst_n === 1'b1 && cycles < 100) begin
            tick();
            cycles++;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        logic [31:0] d;
        int n;
        int low_seen;

        bus.address      = '0;
        bus.data_in      = '0;
        bus.data_write_n = 2'b11;
        bus.data_read_n  = 2'b11;

        repeat (3) tick();
        chk("rst_wdt_rst_n", {31'b0, wdt_rst_n}, 32'd1);
        chk("rst_irq", {31'b0, irq}, 32'd0);
        rd(A_STATUS, d); chk("rst_status", d, 32'h0);
        rd(A_GRACE, d);  chk("rst_grace", d, 32'd1000);
        rd(A_CTRL, d);   chk("rst_ctrl", d, 32'h0);
        chk("data_ready", {31'b0, bus.data_ready}, 32'd1);
        rst_n = 1'b1;
        tick();

        // 1: GRACE=5 expiry -> bite 7 edges after the first expired edge, 16 cycles wide
        wr(A_GRACE, 32'd5, 2'b10);
        wr(A_CTRL, 32'h1, 2'b10);
        wdt_expired = 1'b1;
        wait_low(n);
        chk("t1_fall_latency", n, 7);
        wait_high(n);
        chk("t1_pulse_len", n, 16);
        rd(A_STATUS, d); chk("t1_status_holdoff", d, 32'h0000_010F);
        chk("t1_irq", {31'b0, irq}, 32'd1);
        repeat (3) tick();
        rd(A_STATUS, d); chk("t1_holdoff_stays", d, 32'h0000_010F);
        wdt_expired = 1'b0;
        tick();
        rd(A_STATUS, d); chk("t1_status_idle", d, 32'h0000_010C);

        // 2: pat on the 4th WARN cycle cancels; W1C clears irq, enable kept
        wr(A_CLEAR, 32'h0, 2'b10);
        rd(A_STATUS, d); chk("t2_clear", d, 32'h0);
        wr(A_GRACE, 32'd10, 2'b10);
        wdt_expired = 1'b1;
        bus.address = A_STATUS;
        low_seen = 0;
        repeat (4) begin
            tick();
            if (wdt_rst_n !== 1'b1) low_seen = 1;
        end
        chk("t2_in_warn", {30'b0, bus.data_out[1:0]}, 32'd1);
        wdt_pat = 1'b1;
        tick();
        wdt_pat = 1'b0;
        wdt_expired = 1'b0;
        #1;
        chk("t2_pat_idle", {30'b0, bus.data_out[1:0]}, 32'd0);
        repeat (20) begin
            tick();
            if (wdt_rst_n !== 1'b1) low_seen = 1;
        end
        chk("t2_no_bite", low_seen, 0);
        chk("t2_irq_set", {31'b0, irq}, 32'd1);
        wr(A_CTRL, 32'h3, 2'b10);
        chk("t2_irq_cleared", {31'b0, irq}, 32'd0);
        rd(A_CTRL, d); chk("t2_enable_kept", d, 32'h1);

        // 3: pat on the cnt==0 cycle wins over the bite; force in the same cycle wins over pat
        wr(A_GRACE, 32'd2, 2'b10);
        wdt_expired = 1'b1;
        repeat (3) tick();
        wdt_pat = 1'b1;
        tick();
        wdt_pat = 1'b0;
        wdt_expired = 1'b0;
        chk("t3_pat_no_bite", {31'b0, wdt_rst_n}, 32'd1);
        rd(A_STATUS, d); chk("t3_status_idle", d, 32'h0000_0004);
        tick();
        wdt_expired = 1'b1;
        repeat (3) tick();
        wdt_pat = 1'b1;
        bus.address = A_CTRL;
        bus.data_in = 32'h5;
        bus.data_write_n = 2'b10;
        tick();
        wdt_pat = 1'b0;
        bus.data_write_n = 2'b11;
        wdt_expired = 1'b0;
        chk("t3_force_bite", {31'b0, wdt_rst_n}, 32'd0);
        rd(A_STATUS, d); chk("t3_status_bite", d, 32'h0000_010E);
        wait_high(n);
        chk("t3_pulse_len", n, 16);
        tick();

        // 4: forced bite with enable=0, then saturation of the bite counter
        wr(A_CTRL, 32'h0, 2'b10);
        wr(A_CLEAR, 32'h0, 2'b10);
        wr(A_CTRL, 32'h4, 2'b10);
        chk("t4_force_low", {31'b0, wdt_rst_n}, 32'd0);
        wait_high(n);
        chk("t4_pulse_len", n, 16);
        rd(A_STATUS, d); chk("t4_status", d, 32'h0000_010B);
        tick();
        for (int i = 0; i < 255; i++) begin
            wr(A_CTRL, 32'h4, 2'b10);
            repeat (17) tick();
        end
        rd(A_STATUS, d); chk("t4_saturated", d, 32'h0000_FF08);

        // 5: synchronous reset in the 8th BITE cycle
        wr(A_GRACE, 32'h55, 2'b10);
        wr(A_CTRL, 32'h4, 2'b10);
        repeat (7) tick();
        chk("t5_mid_bite", {31'b0, wdt_rst_n}, 32'd0);
        rst_n = 1'b0;
        tick();
        chk("t5_rst_release", {31'b0, wdt_rst_n}, 32'd1);
        rd(A_STATUS, d); chk("t5_status", d, 32'h0);
        rd(A_GRACE, d);  chk("t5_grace", d, 32'd1000);
        chk("t5_irq", {31'b0, irq}, 32'd0);
        rst_n = 1'b1;
        tick();

        // 6: GRACE lane writes, CLEAR, unmapped reads, GRACE=0 latency
        wr(A_GRACE, 32'h1234_5678, 2'b10);
        wr(A_GRACE, 32'hFFFF_FFAB, 2'b00);
        rd(A_GRACE, d); chk("t6_grace_8b", d, 32'h1234_56AB);
        wr(A_GRACE, 32'hFFFF_CDEF, 2'b01);
        rd(A_GRACE, d); chk("t6_grace_16b", d, 32'h1234_CDEF);
        wr(A_CTRL, 32'h4, 2'b10);
        wait_high(n);
        tick();
        rd(A_STATUS, d); chk("t6_status_pre", d, 32'h0000_0108);
        wr(A_CLEAR, 32'h0, 2'b00);
        rd(A_STATUS, d); chk("t6_status_clear", d, 32'h0);
        rd(A_CLEAR, d);  chk("t6_clear_read", d, 32'h0);
        rd(6'h20, d);    chk("t6_unmapped", d, 32'h0);
        wr(A_GRACE, 32'h0, 2'b10);
        wr(A_CTRL, 32'h1, 2'b10);
        wdt_expired = 1'b1;
        wait_low(n);
        chk("t6_grace0_latency", n, 2);
        wdt_expired = 1'b0;
        wait_high(n);
        chk("t6_grace0_pulse", n, 16);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
